adc_sdo_tx: RTL and testbench
=============================

// Module: adc_sdo_tx
// PURPOSE
//  Transmit side of the ADC serial link: the ADC-device end that frames parallel samples onto cs_n/sclk/sdo.
//  Serves as a bit-accurate ADC model for ADC reader benches and as a board-to-board sample streamer.
//  Frame: cs_n low, LEAD_ZEROS zero bits, then DATA_W data bits MSB-first. sdo changes on sclk fall; the receiver samples on sclk rise.
//  One-entry holding buffer gives back-to-back frames separated only by the configured gap.
// PARAMETERS
//  DATA_W      12  sample width in bits
//  LEAD_ZEROS  4   zero bits sent before data (0 legal)
//  CLK_DIV     2   clk cycles per sclk half-period, D (>=1)
//  GAP_BITS    1   bit periods cs_n stays high between frames (>=1)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst_n       in   1       synchronous reset, active-low
//  s_data      in   DATA_W  sample to transmit
//  s_valid     in   1       s_data valid
//  s_ready     out  1       holding buffer empty; transfer when s_valid&&s_ready
//  cs_n        out  1       frame select, low during frame
//  sclk        out  1       serial clock, idles high
//  sdo         out  1       serial data
//  busy        out  1       high from frame load until gap end
//  frame_done  out  1       1-cycle pulse on the cycle cs_n rises
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cs_n=1, sclk=1, sdo=0, busy=0, frame_done=0, s_ready=0, buffer cleared, FSM->IDLE.
//   s_ready=1 from the first cycle after rst_n=1. All outputs are registered.
//  Let N=LEAD_ZEROS+DATA_W. Shift word = {LEAD_ZEROS'0, sample}, sent MSB first.
//  FSM IDLE -> FRAME -> GAP -> IDLE:
//   IDLE: when the buffer is full, load the shift reg, free the buffer (s_ready=1 next cycle), and go to FRAME.
//   FRAME entry cycle T0: cs_n=0, sclk=1, sdo=bit0, busy=1.
//    sclk toggles every D cycles: fall T0+D, rise T0+2D, and so on.
//    sdo does not change on the first fall. It advances one bit on each later fall.
//    bit k is stable at the rise at T0+(2k+2)D.
//    After the N-th rise, hold D cycles. At T0+(2N+1)D: cs_n=1, sclk=1, sdo=0, frame_done=1, go to GAP.
//    cs_n is low for exactly (2N+1)D cycles.
//   GAP: cs_n high for GAP_BITS*2*D cycles. Then: if the buffer is full, go to FRAME immediately (the next cycle is the new T0).
//    Otherwise go to IDLE and drop busy.
//  Buffer: accept whenever empty, in any state, including during FRAME/GAP.
//   If the buffer is full, s_ready=0; s_data/s_valid must be held by the source.
//   Accept and load in the same cycle: load takes the old entry, the new entry is written, no loss.
//  Simultaneous: frame_done and acceptance may coincide. Reset overrides everything.
//  Reset mid-frame: frame aborted. Next cycle cs_n=1, sclk=1, sdo=0, no frame_done, buffered sample discarded.
//  Counters: half-period counter $clog2(D) bits (min 1); bit counter $clog2(N+1) bits; gap counter sized for GAP_BITS*2*D.
//   All counters wrap-free: they are reloaded, not free-running.
//  No combinational path from s_valid to any output.
// STRUCTURE
//  Package adc_pkg: ADC_DATA_W=12, ADC_LEAD_ZEROS=4, typedef enum logic[1:0] {IDLE,FRAME,GAP} adc_tx_state_t.
//  Sub-module sclk_tick_gen: clk-enable pulse every CLK_DIV cycles.
//   Restarted (sync clear) at frame start so T0 alignment is exact.
//  Top: FSM, shift register, holding buffer, bit/gap counters.
// TESTING
//  1 D=2, push 12'hF9F at idle -> cs_n low 66 cycles; sdo at 16 rises = 0000_1111_1001_1111; one frame_done.
//  2 Push 12'hABC then 12'h123 back-to-back -> second accepted during frame 1; cs_n high exactly 4 cycles between frames; both words correct.
//  3 Hold s_valid with a 3rd sample while the buffer is full -> s_ready=0 until frame 2 load; sample sent as frame 3, none lost or duplicated.
//  4 rst_n=0 at T0+20 with a sample buffered -> next cycle cs_n=1, sclk=1, sdo=0; no frame_done; no frame after release without new push.
//  5 CLK_DIV=1, LEAD_ZEROS=0, push 12'h800 -> cs_n low 25 cycles; sdo=1 only at the first rise.
//  6 Random samples/valid gaps, scoreboard receiver sampling sdo on sclk rise while cs_n=0 -> all words match, in order.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the ADC serial transmit path.
package adc_pkg;

    localparam int unsigned ADC_DATA_W     = 12;
    localparam int unsigned ADC_LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } adc_tx_state_t;

    // Counter width able to hold values up to n-1, never narrower than one bit.
    function automatic int unsigned ctr_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/adc_sdo_tx_if.sv
// Sample-stream handshake plus the cs_n/sclk/sdo serial link of the ADC transmitter.
interface adc_sdo_tx_if
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_DATA_W
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              cs_n;
    logic              sclk;
    logic              sdo;
    logic              busy;
    logic              frame_done;

    // Sample source and serial receiver side.
    modport master (
        output s_data, s_valid,
        input  s_ready, cs_n, sclk, sdo, busy, frame_done
    );

    // Transmitter side.
    modport slave (
        input  s_data, s_valid,
        output s_ready, cs_n, sclk, sdo, busy, frame_done
    );

endinterface

// File: rtl/sclk_tick_gen.sv
// Clock-enable pulse every CLK_DIV cycles; sync clear realigns the phase to a frame start.
module sclk_tick_gen
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = ctr_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_c = (cnt_q == LAST);

endmodule

// File: rtl/adc_sdo_tx.sv
// ADC-device end of the serial link: frames buffered samples onto cs_n/sclk/sdo, MSB first.
module adc_sdo_tx
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_DATA_W,
    parameter int unsigned LEAD_ZEROS = ADC_LEAD_ZEROS,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_BITS   = 1
) (
    input logic         clk,
    input logic         rst_n,
    adc_sdo_tx_if.slave bus
);

    localparam int unsigned N  = LEAD_ZEROS + DATA_W;
    localparam int unsigned G  = GAP_BITS * 2 * CLK_DIV;
    localparam int unsigned BW = ctr_w(N + 1);
    localparam int unsigned GW = ctr_w(G);
    localparam logic [BW-1:0] BIT_LAST = BW'(N);
    localparam logic [GW-1:0] GAP_LOAD = GW'(G - 1);

    adc_tx_state_t     state_q, state_d;
    logic [N-1:0]      sr_q, sr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              full_q, full_d;
    logic              ready_q, ready_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              fd_q, fd_d;
    logic              tick_c;
    logic              load_c;
    logic              accept_c;

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (load_c),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        buf_d    = buf_q;
        full_d   = full_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        fd_d     = 1'b0;
        load_c   = 1'b0;
        accept_c = bus.s_valid && ready_q;

        case (state_q)
            IDLE: begin
                if (full_q) load_c = 1'b1;
            end
            FRAME: begin
                if (tick_c) begin
                    if (sclk_q) begin
                        // A fall after the N-th rise ends the frame instead of dropping sclk.
                        if (bit_q == BIT_LAST) begin
                            state_d = GAP;
                            cs_n_d  = 1'b1;
                            sr_d    = '0;
                            fd_d    = 1'b1;
                            gap_d   = GAP_LOAD;
                        end else begin
                            sclk_d = 1'b0;
                            if (bit_q != '0) sr_d = sr_q << 1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + BW'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (full_q) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            state_d = FRAME;
            sr_d    = N'(buf_q);
            bit_d   = '0;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b1;
            busy_d  = 1'b1;
        end

        if (accept_c) begin
            full_d = 1'b1;
            buf_d  = bus.s_data;
        end else if (load_c) begin
            full_d = 1'b0;
        end
        ready_d = !full_d;
    end

    assign bus.s_ready    = ready_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.sclk       = sclk_q;
    assign bus.sdo        = sr_q[N-1];
    assign bus.busy       = busy_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_adc_sdo_tx.sv
// Directed bench for adc_sdo_tx: framing, timing, buffering, reset abort and a randomized stream.
module tb_adc_sdo_tx;
    import adc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_sdo_tx_if #(.DATA_W(ADC_DATA_W)) if0 ();
    adc_sdo_tx_if #(.DATA_W(ADC_DATA_W)) if1 ();

    adc_sdo_tx #(.DATA_W(ADC_DATA_W), .LEAD_ZEROS(ADC_LEAD_ZEROS), .CLK_DIV(2), .GAP_BITS(1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    adc_sdo_tx #(.DATA_W(ADC_DATA_W), .LEAD_ZEROS(0), .CLK_DIV(1), .GAP_BITS(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    int checks = 0;
    int failures = 0;

    // Receiver model for u0: samples sdo on sclk rise while cs_n is low.
    logic        prev_cs0 = 1'b1, prev_sclk0 = 1'b1, in_gap0 = 1'b0;
    logic [31:0] sh0 = '0;
    int          nb0 = 0, low0 = 0, high0 = 0, falls0 = 0, aborts0 = 0, fd0 = 0;
    logic [31:0] words0[$];
    int          lows0[$], nbits0[$], gaps0[$];

    always @(negedge clk) begin
        if (!if0.cs_n) begin
            if (prev_cs0) begin
                sh0 <= '0;
                nb0 <= 0;
                low0 <= 1;
                falls0 <= falls0 + 1;
                if (in_gap0) gaps0.push_back(high0);
                in_gap0 <= 1'b0;
            end else begin
                low0 <= low0 + 1;
                if (!prev_sclk0 && if0.sclk) begin
                    sh0 <= {sh0[30:0], if0.sdo};
                    nb0 <= nb0 + 1;
                end
            end
        end else begin
            if (!prev_cs0) begin
                high0 <= 1;
                if (if0.frame_done) begin
                    words0.push_back(sh0);
                    lows0.push_back(low0);
                    nbits0.push_back(nb0);
                    in_gap0 <= 1'b1;
                end else begin
                    aborts0 <= aborts0 + 1;
                    in_gap0 <= 1'b0;
                end
            end else begin
                high0 <= high0 + 1;
            end
        end
        if (if0.frame_done) fd0 <= fd0 + 1;
        prev_cs0 <= if0.cs_n;
        prev_sclk0 <= if0.sclk;
    end

    // Receiver model for u1.
    logic        prev_cs1 = 1'b1, prev_sclk1 = 1'b1;
    logic [31:0] sh1 = '0;
    int          nb1 = 0, low1 = 0;
    logic [31:0] words1[$];
    int          lows1[$], nbits1[$];

    always @(negedge clk) begin
        if (!if1.cs_n) begin
            if (prev_cs1) begin
                sh1 <= '0;
                nb1 <= 0;
                low1 <= 1;
            end else begin
                low1 <= low1 + 1;
                if (!prev_sclk1 && if1.sclk) begin
                    sh1 <= {sh1[30:0], if1.sdo};
                    nb1 <= nb1 + 1;
                end
            end
        end else if (!prev_cs1 && if1.frame_done) begin
            words1.push_back(sh1);
            lows1.push_back(low1);
            nbits1.push_back(nb1);
        end
        prev_cs1 <= if1.cs_n;
        prev_sclk1 <= if1.sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample into u0 (sel=0) or u1 (sel=1); waited counts negedges spent with s_ready low.
    task automatic push(input bit sel, input logic [11:0] d, output int waited);
        logic rdy;
        waited = 0;
        if (sel) begin if1.s_data = d; if1.s_valid = 1'b1; end
        else begin if0.s_data = d; if0.s_valid = 1'b1; end
        rdy = sel ? if1.s_ready : if0.s_ready;
        while (!rdy && waited < 400) begin
            @(negedge clk);
            waited++;
            rdy = sel ? if1.s_ready : if0.s_ready;
        end
        chk("push_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        if (sel) if1.s_valid = 1'b0;
        else if0.s_valid = 1'b0;
    endtask

    task automatic wait_frames0(input int n, input int budget);
        int c = 0;
        while (words0.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("frames0_count", 32'(words0.size()), 32'(n));
    endtask

    task automatic wait_idle0();
        int c = 0;
        while (if0.busy && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("idle0_busy", 32'(if0.busy), 32'd0);
    endtask

    initial begin
        int w;
        int c;
        int base;
        int fd_before;
        int falls_before;
        int nwords;
        logic [11:0] d;
        logic [11:0] exp_q[$];

        if0.s_valid = 1'b0; if0.s_data = '0;
        if1.s_valid = 1'b0; if1.s_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n", 32'(if0.cs_n), 32'd1);
        chk("rst_sclk", 32'(if0.sclk), 32'd1);
        chk("rst_sdo", 32'(if0.sdo), 32'd0);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_frame_done", 32'(if0.frame_done), 32'd0);
        chk("rst_s_ready", 32'(if0.s_ready), 32'd0);
        chk("rst_u1_cs_n", 32'(if1.cs_n), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(if0.s_ready), 32'd1);

        // Single frame at idle.
        push(1'b0, 12'hF9F, w);
        wait_frames0(1, 200);
        chk("t1_cs_low", 32'(lows0[0]), 32'd66);
        chk("t1_word", words0[0], 32'h0000_0F9F);
        chk("t1_bits", 32'(nbits0[0]), 32'd16);
        wait_idle0();
        chk("t1_frame_done_cnt", 32'(fd0), 32'd1);

        // Back-to-back frames, then a third sample held while the buffer is full.
        push(1'b0, 12'hABC, w);
        push(1'b0, 12'h123, w);
        chk("t2_accept_in_frame", 32'(if0.cs_n), 32'd0);
        chk("t2_busy", 32'(if0.busy), 32'd1);
        push(1'b0, 12'h5A5, w);
        chk("t3_ready_low_cycles", 32'(w), 32'd69);
        chk("t3_accept_in_frame2", 32'(if0.cs_n), 32'd0);
        wait_frames0(4, 400);
        chk("t2_word1", words0[1], 32'h0000_0ABC);
        chk("t2_word2", words0[2], 32'h0000_0123);
        chk("t3_word3", words0[3], 32'h0000_05A5);
        chk("t2_gap12", 32'(gaps0[1]), 32'd4);
        chk("t3_gap23", 32'(gaps0[2]), 32'd4);
        chk("t2_cs_low2", 32'(lows0[2]), 32'd66);
        wait_idle0();
        repeat (20) @(negedge clk);
        chk("t3_no_dup", 32'(words0.size()), 32'd4);
        chk("t3_frame_done_cnt", 32'(fd0), 32'd4);

        // Reset mid-frame with a sample buffered.
        push(1'b0, 12'h111, w);
        c = 0;
        while (if0.cs_n && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("t4_frame_start", 32'(if0.cs_n), 32'd0);
        push(1'b0, 12'h222, w);
        repeat (19) @(negedge clk);
        chk("t4_in_frame", 32'(if0.cs_n), 32'd0);
        chk("t4_buffered", 32'(if0.s_ready), 32'd0);
        fd_before = fd0;
        nwords = words0.size();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_cs_n", 32'(if0.cs_n), 32'd1);
        chk("t4_sclk", 32'(if0.sclk), 32'd1);
        chk("t4_sdo", 32'(if0.sdo), 32'd0);
        chk("t4_frame_done", 32'(if0.frame_done), 32'd0);
        chk("t4_busy", 32'(if0.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        falls_before = falls0;
        repeat (300) @(negedge clk);
        chk("t4_no_new_frame", 32'(falls0), 32'(falls_before));
        chk("t4_no_frame_done", 32'(fd0), 32'(fd_before));
        chk("t4_no_word", 32'(words0.size()), 32'(nwords));
        chk("t4_abort_seen", 32'(aborts0), 32'd1);

        // Minimal divider, no lead zeros.
        push(1'b1, 12'h800, w);
        c = 0;
        while (words1.size() < 1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t5_frames", 32'(words1.size()), 32'd1);
        chk("t5_cs_low", 32'(lows1[0]), 32'd25);
        chk("t5_word", words1[0], 32'h0000_0800);
        chk("t5_bits", 32'(nbits1[0]), 32'd12);

        // Random samples with random idle gaps.
        base = words0.size();
        for (int i = 0; i < 8; i++) begin
            d = 12'($urandom_range(0, 4095));
            exp_q.push_back(d);
            push(1'b0, d, w);
            repeat ($urandom_range(0, 90)) @(negedge clk);
        end
        wait_frames0(base + 8, 2000);
        for (int i = 0; i < 8; i++) begin
            chk("t6_word", words0[base + i], 32'(exp_q[i]));
            chk("t6_cs_low", 32'(lows0[base + i]), 32'd66);
        end
        wait_idle0();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
